uart_word_sender: RTL and testbench

//   Parametrised multi-byte UART transmitter with built-in baud timing and a

---
 rtl/uart_word_if.sv | 11 +
 rtl/uart_word_sender.sv | 138 +++++++++++++
 tb/tb_uart_word_sender.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_if.sv
// Word handshake between a producer and the UART word sender.
interface uart_word_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_word_sender.sv
// Multi-byte UART transmitter: latches a WIDTH-bit word on accept and sends it
// as WIDTH/8 back-to-back 8N/8P frames with 1 or 2 stop bits.
module uart_word_sender #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_word_if.slave s,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CPB    = CLK_HZ / BAUD;
  localparam int unsigned CNT_W  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned BYTE_W = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]  left_q, left_d;
  logic [WIDTH-1:0]   word_q, word_d;

  logic       txd_d, ready_d, busy_d, done_d;
  logic       tick, accept, load, last_d;
  logic [7:0] cur_byte;

  assign tick   = (baud_q == CNT_W'(CPB - 1));
  assign accept = s.in_valid && s.in_ready;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      left_q     <= '0;
      word_q     <= '0;
      txd        <= 1'b1;
      s.in_ready <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      left_q     <= left_d;
      word_q     <= word_d;
      txd        <= txd_d;
      s.in_ready <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state; the bit counter doubles as the stop-bit counter
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    left_d  = left_q;
    word_d  = word_q;
    load    = 1'b0;
    if (state_q != IDLE && !tick) baud_d = baud_q + CNT_W'(1);
    case (state_q)
      IDLE: if (accept) load = 1'b1;
      START: if (tick) begin
        state_d = DATA;
        baud_d  = '0;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        baud_d = '0;
        if (bit_q == 3'd7) begin
          bit_d   = '0;
          state_d = (PARITY != 0) ? PAR : STOP;
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      PAR: if (tick) begin
        state_d = STOP;
        baud_d  = '0;
        bit_d   = '0;
      end
      STOP: if (tick) begin
        baud_d = '0;
        if (bit_q == 3'(STOP_BITS - 1)) begin
          if (left_q == BYTE_W'(1)) begin
            if (accept) load = 1'b1;
            else        state_d = IDLE;
          end else begin
            left_d  = left_q - BYTE_W'(1);
            word_d  = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);
            state_d = START;
            bit_d   = '0;
          end
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      word_d  = s.in_data;
      left_d  = BYTE_W'(NBYTES);
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
    end
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    cur_byte = (MSB_FIRST != 0) ? word_d[WIDTH-1 -: 8] : word_d[7:0];
    last_d   = (state_d == STOP) && (bit_d == 3'(STOP_BITS - 1)) &&
               (left_d == BYTE_W'(1)) && (baud_d == CNT_W'(CPB - 1));
    txd_d    = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_d];
      PAR:     txd_d = (^cur_byte) ^ (PARITY == 1);
      default: txd_d = 1'b1;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE) || last_d;
    done_d  = last_d;
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: three configurations, per-cycle line scoreboard.
module tb_uart_word_sender;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;

  uart_word_if #(.WIDTH(16)) if0 ();
  uart_word_if #(.WIDTH(16)) if1 ();
  uart_word_if #(.WIDTH(8))  if2 ();

  assign if0.in_valid = valid && (sel == 0);
  assign if1.in_valid = valid && (sel == 1);
  assign if2.in_valid = valid && (sel == 2);
  assign if0.in_data  = data;
  assign if1.in_data  = data;
  assign if2.in_data  = data[7:0];

  logic txd0, busy0, done0, txd1, busy1, done1, txd2, busy2, done2;

  uart_word_sender #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WIDTH(16), .MSB_FIRST(1),
                     .PARITY(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .s(if0), .txd(txd0), .busy(busy0), .done(done0));
  uart_word_sender #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WIDTH(16), .MSB_FIRST(0),
                     .PARITY(0), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .s(if1), .txd(txd1), .busy(busy1), .done(done1));
  uart_word_sender #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .WIDTH(8), .MSB_FIRST(1),
                     .PARITY(2), .STOP_BITS(2))
    u2 (.clk(clk), .rst(rst), .s(if2), .txd(txd2), .busy(busy2), .done(done2));

  logic txd_s, busy_s, done_s, rdy_s;
  always_comb begin
    case (sel)
      0:       begin txd_s = txd0; busy_s = busy0; done_s = done0; rdy_s = if0.in_ready; end
      1:       begin txd_s = txd1; busy_s = busy1; done_s = done1; rdy_s = if1.in_ready; end
      default: begin txd_s = txd2; busy_s = busy2; done_s = done2; rdy_s = if2.in_ready; end
    endcase
  end

  int cfg_par  [3] = '{0, 0, 2};
  int cfg_stop [3] = '{1, 1, 2};
  int cfg_nb   [3] = '{2, 2, 1};

  typedef struct packed {
    logic txd;
    logic done;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          cfg;
    logic [15:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vt[7];

  int n_cmp = 0;
  int n_bad = 0;

  bit          chain_en = 1'b0;
  logic [15:0] chain_data;
  logic [7:0]  chain_b0, chain_b1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b);
    repeat (CPB) exp_q.push_back('{txd: b, done: 1'b0});
  endtask

  // Line model: start, 8 data bits LSB first, optional parity, stop bits
  task automatic push_word(input int cfg, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] by;
    for (int i = 0; i < cfg_nb[cfg]; i++) begin
      by = (i == 0) ? b0 : b1;
      push_bit(1'b0);
      for (int j = 0; j < 8; j++) push_bit(by[j]);
      if (cfg_par[cfg] == 1) push_bit(~(^by));
      if (cfg_par[cfg] == 2) push_bit(^by);
      for (int k = 0; k < cfg_stop[cfg]; k++) push_bit(1'b1);
    end
    exp_q[exp_q.size()-1].done = 1'b1;
  endtask

  task automatic send(input int cfg, input logic [15:0] d, input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    sel = cfg;
    #1;
    check("ready_before_accept", rdy_s, 1'b1);
    valid = 1'b1;
    data  = d;
    push_word(cfg, b0, b1);
    @(posedge clk);
  endtask

  // Pop one expected entry per cycle; inputs are scrambled while busy
  task automatic drain(input int limit);
    exp_t e;
    int   k = 0;
    while (exp_q.size() > 0 && k < limit) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("txd", txd_s, e.txd);
      check("done", done_s, e.done);
      check("busy", busy_s, 1'b1);
      check("in_ready", rdy_s, e.done);
      k++;
      if (e.done && chain_en) begin
        valid = 1'b1;
        data  = chain_data;
        push_word(sel, chain_b0, chain_b1);
        chain_en = 1'b0;
      end else begin
        valid = e.done ? 1'b0 : 1'($urandom_range(0, 1));
        data  = 16'($urandom());
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_txd", txd_s, 1'b1);
    check("idle_busy", busy_s, 1'b0);
    check("idle_done", done_s, 1'b0);
    check("idle_ready", rdy_s, 1'b1);
  endtask

  initial begin
    vt[0] = '{0, 16'hA55A, 8'hA5, 8'h5A};
    vt[1] = '{1, 16'hA55A, 8'h5A, 8'hA5};
    vt[2] = '{2, 16'h0007, 8'h07, 8'h00};
    vt[3] = '{0, 16'h1234, 8'h12, 8'h34};
    vt[4] = '{1, 16'h00FF, 8'hFF, 8'h00};
    vt[5] = '{2, 16'h0000, 8'h00, 8'h00};
    vt[6] = '{2, 16'h00FE, 8'hFE, 8'h00};

    // Async reset pulse strictly between clock edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_txd0", txd0, 1'b1);   check("rst_busy0", busy0, 1'b0);
    check("rst_done0", done0, 1'b0); check("rst_rdy0", if0.in_ready, 1'b1);
    check("rst_txd1", txd1, 1'b1);   check("rst_rdy1", if1.in_ready, 1'b1);
    check("rst_txd2", txd2, 1'b1);   check("rst_rdy2", if2.in_ready, 1'b1);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(vt[i].cfg, vt[i].data, vt[i].b0, vt[i].b1);
      drain(100000);
      idle_check();
    end

    // Second word waiting during the done cycle: zero-gap continuation
    chain_en   = 1'b1;
    chain_data = 16'h3CC3;
    chain_b0   = 8'h3C;
    chain_b1   = 8'hC3;
    send(0, 16'hA55A, 8'hA5, 8'h5A);
    drain(100000);
    idle_check();

    // Reset in the middle of a word
    send(0, 16'hA55A, 8'hA5, 8'h5A);
    drain(57);
    valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("abort_txd", txd_s, 1'b1);
    check("abort_busy", busy_s, 1'b0);
    check("abort_done", done_s, 1'b0);
    check("abort_ready", rdy_s, 1'b1);
    #1 rst = 1'b0;
    exp_q.delete();
    repeat (25) begin
      @(negedge clk);
      check("abort_quiet_done", done_s, 1'b0);
      check("abort_quiet_txd", txd_s, 1'b1);
    end
    send(0, 16'hC35A, 8'hC3, 8'h5A);
    drain(100000);
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
